// File: rtl/cla_adder_4bit.sv
// 4-bit carry-look-ahead adder with group propagate/generate outputs for
// cascading, plus an optional registered copy of sum/carry for pipelined use.
module cla_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  input  logic       in_valid,
  output logic [3:0] S,
  output logic       C_out,
  output logic       P_grp,
  output logic       G_grp,
  output logic       OVF,
  output logic [3:0] S_r,
  output logic       C_out_r,
  output logic       out_valid
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Per-bit propagate/generate terms
  always_comb begin
    p = A ^ B;
    g = A & B;
  end

  // Flat two-level look-ahead carries; no carry ripples through another carry
  always_comb begin
    c[0] = C_in;
    c[1] = g[0] | (p[0] & C_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & C_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & C_in);
  end

  // Sum, carry out, group terms and signed overflow
  always_comb begin
    S     = p ^ c[3:0];
    C_out = c[4];
    P_grp = &p;
    // c4 with the carry-in term dropped
    G_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    OVF   = c[3] ^ c[4];
  end

  // Registered result stage: capture on in_valid, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      S_r       <= '0;
      C_out_r   <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S_r       <= S;
      C_out_r   <= C_out;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_adder_4bit.sv
// Scoreboard bench for cla_adder_4bit: stimulus pushes expected responses,
// a monitor pops one entry per clock and compares combinational and
// registered outputs.
module tb_cla_adder_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       C_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] S;
  logic       C_out, P_grp, G_grp, OVF;
  logic [3:0] S_r;
  logic       C_out_r, out_valid;

  cla_adder_4bit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C_in(C_in), .in_valid(in_valid),
    .S(S), .C_out(C_out), .P_grp(P_grp), .G_grp(G_grp), .OVF(OVF),
    .S_r(S_r), .C_out_r(C_out_r), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, c;
    int s, co, p, g, ovf;
    int v, sr, cor;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   model_sr = 0;
  int   model_cor = 0;

  function automatic int to_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input exp_t e);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: A=%0d B=%0d Cin=%0d got %0d expected %0d", name, e.a, e.b, e.c, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and enqueue what the DUT must show
  task automatic apply(input int r, input int v, input int a, input int b, input int c);
    exp_t e;
    int sum, ssum;
    @(negedge clk);
    rst = r[0]; in_valid = v[0]; A = a[3:0]; B = b[3:0]; C_in = c[0];
    sum  = a + b + c;
    ssum = to_signed4(a) + to_signed4(b) + c;
    e.a = a; e.b = b; e.c = c;
    e.s   = sum % 16;
    e.co  = (sum >= 16) ? 1 : 0;
    e.g   = (a + b >= 16) ? 1 : 0;
    e.p   = (a + b == 15) ? 1 : 0;
    e.ovf = (ssum > 7 || ssum < -8) ? 1 : 0;
    if (r != 0) begin
      model_sr = 0; model_cor = 0; e.v = 0;
    end else if (v != 0) begin
      model_sr = e.s; model_cor = e.co; e.v = 1;
    end else begin
      e.v = 0;
    end
    e.sr = model_sr; e.cor = model_cor;
    q.push_back(e);
  endtask

  // Monitor: combinational outputs before the edge, registered ones just after
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("S",     int'(S),     e.s,   e);
        chk("C_out", int'(C_out), e.co,  e);
        chk("P_grp", int'(P_grp), e.p,   e);
        chk("G_grp", int'(G_grp), e.g,   e);
        chk("OVF",   int'(OVF),   e.ovf, e);
        #1;
        chk("out_valid", int'(out_valid), e.v,   e);
        chk("S_r",       int'(S_r),       e.sr,  e);
        chk("C_out_r",   int'(C_out_r),   e.cor, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset two cycles, then registered-path directed sequence
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 3, 11, 0);
    apply(0, 0, 5, 6, 1);
    apply(0, 0, 1, 2, 0);
    // Reset wins over in_valid
    apply(1, 1, 9, 9, 1);
    // Directed combinational corners
    apply(0, 1, 3, 10, 1);
    apply(0, 1, 12, 10, 1);
    apply(0, 1, 13, 10, 1);
    apply(0, 1, 15, 15, 1);
    apply(0, 1, 8, 8, 1);
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 15, 0, 1);
    // Exhaustive sweep of all operand/carry combinations
    for (int unsigned i = 0; i < 512; i++)
      apply(0, int'(i % 3 != 0), int'(i / 32), int'((i / 2) % 16), int'(i % 2));
    // Random traffic with random valid and occasional reset
    for (int unsigned i = 0; i < 300; i++)
      apply(($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)));
    apply(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: scoreboard entries left got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
